// File: rtl/wcd_bus_pkg.sv
// Shared constants for the WCD6502 bus responder: address windows, I/O register
// offsets, the ID byte and CTRL bit positions, plus the address-window decoder.
package wcd_bus_pkg;

  localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
  localparam logic [15:0] IO_BASE   = 16'h4000;
  localparam logic [15:0] IO_LIMIT  = 16'h400F;
  localparam logic [15:0] VEC_BASE  = 16'hFFFA;

  localparam logic [3:0] IO_ID        = 4'h0;
  localparam logic [3:0] IO_SCRATCH   = 4'h1;
  localparam logic [3:0] IO_TMR_L     = 4'h2;
  localparam logic [3:0] IO_TMR_H     = 4'h3;
  localparam logic [3:0] IO_CTRL      = 4'h4;
  localparam logic [3:0] IO_ERRCNT    = 4'h5;
  localparam logic [3:0] IO_ERRADDR_L = 4'h6;
  localparam logic [3:0] IO_ERRADDR_H = 4'h7;

  localparam logic [7:0] ID_VALUE = 8'h65;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ACK    = 3;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_IO   = 2'd1,
    REGION_VEC  = 2'd2,
    REGION_NONE = 2'd3
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr);
    region_e r;
    if (addr <= RAM_LIMIT) begin
      r = REGION_RAM;
    end else if ((addr >= IO_BASE) && (addr <= IO_LIMIT)) begin
      r = REGION_IO;
    end else if (addr >= VEC_BASE) begin
      r = REGION_VEC;
    end else begin
      r = REGION_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/wcd_bus_timer.sv
// Prescaled 16-bit free-running timer with a sticky overflow flag.
// A clear pulse beats a coincident tick; an overflow beats a coincident ack.
module wcd_bus_timer #(
  parameter int PRESCALE = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        run,
  input  logic        clr,
  input  logic        ack,
  output logic [15:0] tick_val,
  output logic        ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_r;
  logic [15:0]   tmr_r;
  logic          ovf_r;
  logic          tick_s;
  logic          wrap_s;

  assign tick_s = run & ~clr & (presc_r == PS_LAST);
  assign wrap_s = tick_s & (tmr_r == 16'hFFFF);

  // prescaler and counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc_r <= {PW{1'b0}};
      tmr_r   <= 16'h0000;
    end else if (clr) begin
      presc_r <= {PW{1'b0}};
      tmr_r   <= 16'h0000;
    end else if (run) begin
      if (presc_r == PS_LAST) begin
        presc_r <= {PW{1'b0}};
        tmr_r   <= tmr_r + 16'd1;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end else begin
      presc_r <= presc_r;
      tmr_r   <= tmr_r;
    end
  end

  // sticky overflow flag
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_r <= 1'b0;
    end else if (wrap_s) begin
      ovf_r <= 1'b1;
    end else if (ack) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign tick_val = tmr_r;
  assign ovf      = ovf_r;

endmodule

// File: rtl/wcd_bus_responder.sv
// Target side of the WCD6502 CPU bus: mirrored work RAM, I/O register window with
// timer, vector ROM, open-bus read latch and illegal-access logging.
module wcd_bus_responder
  import wcd_bus_pkg::*;
#(
  parameter int          RAM_AW   = 11,
  parameter logic [15:0] RST_VEC  = 16'h8000,
  parameter logic [15:0] NMI_VEC  = 16'h8100,
  parameter logic [15:0] IRQ_VEC  = 16'h8200,
  parameter int          PRESCALE = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] AB,
  input  logic [7:0]  DB,
  input  logic        nRD,
  input  logic        nWR,
  output logic [7:0]  DB_OUT,
  output logic        RD_VALID,
  output logic        BUS_ERR,
  output logic        nIRQ
);

  logic [7:0] ram_r [0:(2**RAM_AW)-1];

  logic [7:0]  db_out_r;
  logic        rd_valid_r;
  logic        bus_err_r;
  logic [7:0]  scratch_r;
  logic        run_r;
  logic        irq_en_r;
  logic [7:0]  shadow_r;
  logic [7:0]  errcnt_r;
  logic [15:0] erraddr_r;

  region_e     region_s;
  logic [3:0]  io_off_s;
  logic        rd_s;
  logic        wr_s;
  logic        conflict_s;
  logic        err_s;
  logic [7:0]  rd_data_s;
  logic        rd_hit_s;
  logic [7:0]  ctrl_rd_s;
  logic        ram_we_s;
  logic        scratch_we_s;
  logic        ctrl_we_s;
  logic        errcnt_clr_s;
  logic        wr_illegal_s;
  logic        shadow_ld_s;
  logic        clr_s;
  logic        ack_s;
  logic [15:0] tick_val_s;
  logic        ovf_s;

  assign region_s   = decode_region(AB);
  assign io_off_s   = AB[3:0];
  assign conflict_s = ~nRD & ~nWR;
  assign rd_s       = ~nRD & nWR;
  assign wr_s       = nRD & ~nWR;
  assign err_s      = conflict_s | (wr_s & wr_illegal_s);

  assign shadow_ld_s = rd_s & (region_s == REGION_IO) & (io_off_s == IO_TMR_L);
  assign clr_s       = ctrl_we_s & DB[CTRL_CLR];
  assign ack_s       = ctrl_we_s & DB[CTRL_ACK];

  wcd_bus_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .run     (run_r),
    .clr     (clr_s),
    .ack     (ack_s),
    .tick_val(tick_val_s),
    .ovf     (ovf_s)
  );

  // CTRL readback: the one-shot clear/ack bits always read as zero
  always_comb begin
    ctrl_rd_s              = 8'h00;
    ctrl_rd_s[CTRL_RUN]    = run_r;
    ctrl_rd_s[CTRL_IRQ_EN] = irq_en_r;
  end

  // read mux; rd_hit_s low means open bus
  always_comb begin
    rd_data_s = 8'h00;
    rd_hit_s  = 1'b1;
    case (region_s)
      REGION_RAM: rd_data_s = ram_r[AB[RAM_AW-1:0]];
      REGION_IO: begin
        case (io_off_s)
          IO_ID:        rd_data_s = ID_VALUE;
          IO_SCRATCH:   rd_data_s = scratch_r;
          IO_TMR_L:     rd_data_s = tick_val_s[7:0];
          IO_TMR_H:     rd_data_s = shadow_r;
          IO_CTRL:      rd_data_s = ctrl_rd_s;
          IO_ERRCNT:    rd_data_s = errcnt_r;
          IO_ERRADDR_L: rd_data_s = erraddr_r[7:0];
          IO_ERRADDR_H: rd_data_s = erraddr_r[15:8];
          default:      rd_data_s = 8'h00;
        endcase
      end
      REGION_VEC: begin
        case (AB[2:0])
          3'b010:  rd_data_s = NMI_VEC[7:0];
          3'b011:  rd_data_s = NMI_VEC[15:8];
          3'b100:  rd_data_s = RST_VEC[7:0];
          3'b101:  rd_data_s = RST_VEC[15:8];
          3'b110:  rd_data_s = IRQ_VEC[7:0];
          3'b111:  rd_data_s = IRQ_VEC[15:8];
          default: rd_data_s = 8'hFF;
        endcase
      end
      default: rd_hit_s = 1'b0;
    endcase
  end

  // write decode; anything not explicitly writable is illegal
  always_comb begin
    ram_we_s     = 1'b0;
    scratch_we_s = 1'b0;
    ctrl_we_s    = 1'b0;
    errcnt_clr_s = 1'b0;
    wr_illegal_s = 1'b0;
    if (wr_s) begin
      case (region_s)
        REGION_RAM: ram_we_s = 1'b1;
        REGION_IO: begin
          case (io_off_s)
            IO_SCRATCH: scratch_we_s = 1'b1;
            IO_CTRL:    ctrl_we_s    = 1'b1;
            IO_ERRCNT:  errcnt_clr_s = 1'b1;
            default:    wr_illegal_s = 1'b1;
          endcase
        end
        default: wr_illegal_s = 1'b1;
      endcase
    end else begin
      wr_illegal_s = 1'b0;
    end
  end

  // work RAM is never cleared; reset only suppresses a write in flight
  always_ff @(posedge Clk) begin
    if (ram_we_s && !Rst) begin
      ram_r[AB[RAM_AW-1:0]] <= DB;
    end
  end

  // bus-facing outputs: open-bus data latch and one-cycle pulses
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      db_out_r   <= 8'hFF;
      rd_valid_r <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_s;
      bus_err_r  <= err_s;
      if (rd_s && rd_hit_s) begin
        db_out_r <= rd_data_s;
      end
    end
  end

  // register file, timer shadow and error log
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scratch_r <= 8'h00;
      run_r     <= 1'b0;
      irq_en_r  <= 1'b0;
      shadow_r  <= 8'h00;
      errcnt_r  <= 8'h00;
      erraddr_r <= 16'h0000;
    end else begin
      if (scratch_we_s) begin
        scratch_r <= DB;
      end
      if (ctrl_we_s) begin
        run_r    <= DB[CTRL_RUN];
        irq_en_r <= DB[CTRL_IRQ_EN];
      end
      if (shadow_ld_s) begin
        shadow_r <= tick_val_s[15:8];
      end
      if (errcnt_clr_s) begin
        errcnt_r <= 8'h00;
      end else if (err_s && (errcnt_r != 8'hFF)) begin
        errcnt_r <= errcnt_r + 8'd1;
      end
      if (err_s) begin
        erraddr_r <= AB;
      end
    end
  end

  assign DB_OUT   = db_out_r;
  assign RD_VALID = rd_valid_r;
  assign BUS_ERR  = bus_err_r;
  assign nIRQ     = ~(ovf_s & irq_en_r);

endmodule

// File: tb/tb_wcd_bus_responder.sv
// Self-checking bench: directed vector table, reset/saturation sequences, random
// traffic against a behavioural model, and a long timer/IRQ run at PRESCALE=1.
module tb_wcd_bus_responder;

  localparam int PS = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] AB;
  logic [7:0]  DB;
  logic        nRD;
  logic        nWR;
  logic [7:0]  db_out, db_out_p1;
  logic        rd_valid, rd_valid_p1;
  logic        bus_err, bus_err_p1;
  logic        nirq, nirq_p1;

  int tests = 0;
  int fails = 0;

  wcd_bus_responder #(.PRESCALE(PS)) dut (
    .Clk(Clk), .Rst(Rst), .AB(AB), .DB(DB), .nRD(nRD), .nWR(nWR),
    .DB_OUT(db_out), .RD_VALID(rd_valid), .BUS_ERR(bus_err), .nIRQ(nirq)
  );

  wcd_bus_responder #(.PRESCALE(1)) dut_p1 (
    .Clk(Clk), .Rst(Rst), .AB(AB), .DB(DB), .nRD(nRD), .nWR(nWR),
    .DB_OUT(db_out_p1), .RD_VALID(rd_valid_p1), .BUS_ERR(bus_err_p1), .nIRQ(nirq_p1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  db;
    logic        rd;
    logic        wr;
    logic [7:0]  exp_db;
    logic        exp_v;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state
  logic [7:0] m_ram [0:2047];
  logic [7:0] m_db, m_scratch, m_shadow;
  logic       m_run, m_irqen, m_ovf, m_v, m_e, m_nirq;
  int         m_tmr, m_presc, m_errcnt;
  logic [15:0] m_erraddr;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ab, input logic [7:0] db, input logic rd, input logic wr,
                     input logic [7:0] exp_db, input logic exp_v, input logic exp_e);
    vec_t v;
    v.ab = ab; v.db = db; v.rd = rd; v.wr = wr;
    v.exp_db = exp_db; v.exp_v = exp_v; v.exp_e = exp_e;
    vecs.push_back(v);
  endtask

  // one bus cycle: drive at negedge, sampled at posedge, return at next negedge
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
    AB = a; DB = d; nRD = ~rd; nWR = ~wr;
    @(posedge Clk);
    @(negedge Clk);
    nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic idle();
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Rst = 1'b1; nRD = 1'b1; nWR = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic model_reset();
    m_db = 8'hFF; m_scratch = 8'h00; m_shadow = 8'h00;
    m_run = 1'b0; m_irqen = 1'b0; m_ovf = 1'b0;
    m_tmr = 0; m_presc = 0; m_errcnt = 0; m_erraddr = 16'h0000;
    m_v = 1'b0; m_e = 1'b0; m_nirq = 1'b1;
  endtask

  function automatic logic [7:0] vec_byte(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'h81;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'h80;
      16'hFFFE: return 8'h00;
      default:  return 8'h82;
    endcase
  endfunction

  task automatic model_step(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
    logic old_run, err, clr, ack, wrap, hit;
    logic [7:0] val;
    old_run = m_run; err = 1'b0; clr = 1'b0; ack = 1'b0; wrap = 1'b0; hit = 1'b1; val = 8'h00;
    m_v = 1'b0;
    if (rd && wr) begin
      err = 1'b1;
    end else if (rd) begin
      m_v = 1'b1;
      if (a < 16'h2000) val = m_ram[a[10:0]];
      else if (a >= 16'h4000 && a <= 16'h400F) begin
        case (a[3:0])
          4'h0: val = 8'h65;
          4'h1: val = m_scratch;
          4'h2: begin val = 8'(m_tmr % 256); m_shadow = 8'(m_tmr / 256); end
          4'h3: val = m_shadow;
          4'h4: val = {5'b00000, m_irqen, 1'b0, m_run};
          4'h5: val = 8'(m_errcnt);
          4'h6: val = m_erraddr[7:0];
          4'h7: val = m_erraddr[15:8];
          default: val = 8'h00;
        endcase
      end else if (a >= 16'hFFFA) val = vec_byte(a);
      else hit = 1'b0;
      if (hit) m_db = val;
    end else if (wr) begin
      if (a < 16'h2000) m_ram[a[10:0]] = d;
      else if (a == 16'h4001) m_scratch = d;
      else if (a == 16'h4004) begin
        m_run = d[0]; m_irqen = d[2]; clr = d[1]; ack = d[3];
      end else if (a == 16'h4005) m_errcnt = 0;
      else err = 1'b1;
    end
    m_e = err;
    if (err) begin
      if (m_errcnt < 255) m_errcnt++;
      m_erraddr = a;
    end
    if (clr) begin
      m_tmr = 0; m_presc = 0;
    end else if (old_run) begin
      m_presc++;
      if (m_presc == PS) begin
        m_presc = 0;
        m_tmr = (m_tmr + 1) % 65536;
        if (m_tmr == 0) wrap = 1'b1;
      end
    end
    if (wrap) m_ovf = 1'b1;
    else if (ack) m_ovf = 1'b0;
    m_nirq = ~(m_ovf & m_irqen);
  endtask

  function automatic logic [15:0] rand_addr();
    int c;
    c = $urandom_range(0, 5);
    case (c)
      0, 1: return {3'b000, 2'($urandom), 6'b000000, 5'($urandom)};
      2, 3: return 16'h4000 + 16'($urandom_range(0, 15));
      4:    return 16'hFFFA + 16'($urandom_range(0, 5));
      default: begin
        if ($urandom_range(0, 1) == 0) return 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
        else return 16'h4010 + 16'($urandom_range(0, 16'hBFE9));
      end
    endcase
  endfunction

  initial begin
    Rst = 1'b1; AB = 16'h0000; DB = 8'h00; nRD = 1'b1; nWR = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset DB_OUT", db_out, 8'hFF);
    check("reset RD_VALID", rd_valid, 1'b0);
    check("reset BUS_ERR", bus_err, 1'b0);
    check("reset nIRQ", nirq, 1'b1);
    Rst = 1'b0;

    add(16'hFFFC, 8'h00, 1, 0, 8'h00, 1, 0);
    add(16'hFFFD, 8'h00, 1, 0, 8'h80, 1, 0);
    add(16'h0000, 8'h00, 0, 0, 8'h80, 0, 0);
    add(16'h01FD, 8'hAA, 0, 1, 8'h80, 0, 0);
    add(16'h01FD, 8'h00, 1, 0, 8'hAA, 1, 0);
    add(16'h09FD, 8'h00, 1, 0, 8'hAA, 1, 0);
    add(16'hFFFC, 8'h55, 0, 1, 8'hAA, 0, 1);
    add(16'h0200, 8'h77, 1, 1, 8'hAA, 0, 1);
    add(16'h0000, 8'h00, 0, 0, 8'hAA, 0, 0);
    add(16'h4005, 8'h00, 1, 0, 8'h02, 1, 0);
    add(16'h4006, 8'h00, 1, 0, 8'h00, 1, 0);
    add(16'h4007, 8'h00, 1, 0, 8'h02, 1, 0);
    add(16'h4005, 8'h5A, 0, 1, 8'h02, 0, 0);
    add(16'h4005, 8'h00, 1, 0, 8'h00, 1, 0);
    add(16'h4000, 8'h00, 1, 0, 8'h65, 1, 0);
    add(16'h5000, 8'h00, 1, 0, 8'h65, 1, 0);
    add(16'hFFFA, 8'h00, 1, 0, 8'h00, 1, 0);
    add(16'hFFFB, 8'h00, 1, 0, 8'h81, 1, 0);
    add(16'hFFFF, 8'h00, 1, 0, 8'h82, 1, 0);
    add(16'h4001, 8'h3C, 0, 1, 8'h82, 0, 0);
    add(16'h4001, 8'h00, 1, 0, 8'h3C, 1, 0);
    add(16'h4000, 8'h11, 0, 1, 8'h3C, 0, 1);
    add(16'h4005, 8'h00, 1, 0, 8'h01, 1, 0);
    add(16'h400A, 8'h00, 1, 0, 8'h00, 1, 0);
    add(16'h4004, 8'h0E, 0, 1, 8'h00, 0, 0);
    add(16'h4004, 8'h00, 1, 0, 8'h04, 1, 0);
    foreach (vecs[i]) begin
      cyc(vecs[i].ab, vecs[i].db, vecs[i].rd, vecs[i].wr);
      check($sformatf("vec%0d DB_OUT", i), db_out, vecs[i].exp_db);
      check($sformatf("vec%0d RD_VALID", i), rd_valid, vecs[i].exp_v);
      check($sformatf("vec%0d BUS_ERR", i), bus_err, vecs[i].exp_e);
    end
    check("table nIRQ", nirq, 1'b1);

    // reset in the middle of a write must abort it
    cyc(16'h0300, 8'h11, 0, 1);
    Rst = 1'b1; AB = 16'h0300; DB = 8'hEE; nWR = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("midreset DB_OUT", db_out, 8'hFF);
    Rst = 1'b0; nWR = 1'b1;
    cyc(16'h0300, 8'h00, 1, 0);
    check("midreset RAM kept", db_out, 8'h11);

    // error counter saturation
    for (int i = 0; i < 260; i++) cyc(16'h3000, 8'h00, 0, 1);
    cyc(16'h4005, 8'h00, 1, 0);
    check("errcnt saturate", db_out, 8'hFF);
    cyc(16'h4007, 8'h00, 1, 0);
    check("erraddr hi", db_out, 8'h30);

    // random traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 32; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = {3'b000, 2'($urandom), 11'(i)};
      d = 8'($urandom);
      cyc(a, d, 0, 1);
      model_step(a, d, 1'b0, 1'b1);
      check("preinit BUS_ERR", bus_err, m_e);
    end
    for (int i = 0; i < 800; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        rd, wr;
      int          op;
      a = rand_addr();
      d = 8'($urandom);
      op = $urandom_range(0, 9);
      rd = (op <= 3) || (op == 7);
      wr = (op >= 4) && (op <= 7);
      cyc(a, d, rd, wr);
      model_step(a, d, rd, wr);
      check($sformatf("rand%0d DB_OUT @%h", i, a), db_out, m_db);
      check($sformatf("rand%0d RD_VALID", i), rd_valid, m_v);
      check($sformatf("rand%0d BUS_ERR", i), bus_err, m_e);
      check($sformatf("rand%0d nIRQ", i), nirq, m_nirq);
    end

    // PRESCALE=1 instance: coherent 16-bit read and full wrap to IRQ
    do_reset();
    begin
      int n;
      cyc(16'h4004, 8'h05, 0, 1);
      n = 0;
      while (n < 16'h12FF) begin idle(); n++; end
      cyc(16'h4002, 8'h00, 1, 0); n++;
      check("p1 TMR_L", db_out_p1, 8'hFF);
      repeat (7) begin idle(); n++; end
      cyc(16'h4003, 8'h00, 1, 0); n++;
      check("p1 TMR_H shadow", db_out_p1, 8'h12);
      while (n < 65535) begin idle(); n++; end
      check("p1 nIRQ before wrap", nirq_p1, 1'b1);
      idle();
      check("p1 nIRQ at wrap", nirq_p1, 1'b0);
      idle();
      check("p1 nIRQ held", nirq_p1, 1'b0);
      cyc(16'h4004, 8'h0D, 0, 1);
      check("p1 nIRQ after ack", nirq_p1, 1'b1);
      cyc(16'h4004, 8'h00, 1, 0);
      check("p1 CTRL readback", db_out_p1, 8'h05);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
